cpu_step_5_wb: RTL and testbench

Parametrised write-back stage for the 5-stage CPU pipeline, successor to the two-input ALU/memory select.
- Registers the MEM/WB boundary, then selects one of four result sources.
- Aligns and sign/zero-extends load data, and drives the register-file write port plus a forwarding tap for the hazard unit.
- Supports pipeline flush; optionally counts retired instructions.

---
 rtl/cpu_step_5_wb.sv | 134 +++++++++++++
 tb/tb_cpu_step_5_wb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_5_wb.sv
// Write-back stage: MEM/WB register, four-way result select, load alignment/extension, RF write port + forwarding tap.
// Latency: 1 cycle from in_* capture to wb_*/fwd_*; optional retire counter enabled by `define WB_RETIRE_COUNT_EN.
// Backpressure: none; accepts one instruction per cycle, flush turns the captured slot into a bubble.
module cpu_step_5_wb #(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_flush,
  input  logic [1:0]                   in_sel,
  input  logic [WIDTH-1:0]             in_alu,
  input  logic [WIDTH-1:0]             in_mem,
  input  logic [WIDTH-1:0]             in_pc_plus4,
  input  logic [WIDTH-1:0]             in_imm,
  input  logic [$clog2(REG_COUNT)-1:0] in_rd,
  input  logic                         in_reg_write,
  input  logic [1:0]                   in_load_size,
  input  logic                         in_load_unsigned,
  input  logic [1:0]                   in_byte_offset,
  output logic                         wb_en,
  output logic [$clog2(REG_COUNT)-1:0] wb_addr,
  output logic [WIDTH-1:0]             wb_data,
  output logic                         fwd_valid,
  output logic [$clog2(REG_COUNT)-1:0] fwd_addr,
  output logic [WIDTH-1:0]             fwd_data,
  output logic [31:0]                  retire_count
);

  localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC4 = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [1:0]                sel;
    logic [1:0]                load_size;
    logic                      load_unsigned;
    logic [1:0]                byte_offset;
    logic [WIDTH-1:0]          alu;
    logic [WIDTH-1:0]          mem;
    logic [WIDTH-1:0]          pc_plus4;
    logic [WIDTH-1:0]          imm;
  } stage_t;

  stage_t stage_d;
  stage_t stage_q;

  always_comb begin
    stage_d               = '0;
    stage_d.valid         = in_valid & ~in_flush;
    stage_d.reg_write     = in_reg_write;
    stage_d.rd            = in_rd;
    stage_d.sel           = in_sel;
    stage_d.load_size     = in_load_size;
    stage_d.load_unsigned = in_load_unsigned;
    stage_d.byte_offset   = in_byte_offset;
    stage_d.alu           = in_alu;
    stage_d.mem           = in_mem;
    stage_d.pc_plus4      = in_pc_plus4;
    stage_d.imm           = in_imm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Lanes always come from the low word; the half lane ignores offset bit 0 on purpose.
  logic [31:0]      mem_word;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] result;

  always_comb begin
    mem_word  = stage_q.mem[31:0];
    byte_lane = mem_word[{stage_q.byte_offset, 3'b000} +: 8];
    half_lane = mem_word[{stage_q.byte_offset[1], 4'b0000} +: 16];
    case (stage_q.load_size)
      SIZE_BYTE: load_val = stage_q.load_unsigned ? WIDTH'(byte_lane)
                                                  : WIDTH'($signed(byte_lane));
      SIZE_HALF: load_val = stage_q.load_unsigned ? WIDTH'(half_lane)
                                                  : WIDTH'($signed(half_lane));
      default:   load_val = stage_q.load_unsigned ? WIDTH'(mem_word)
                                                  : WIDTH'($signed(mem_word));
    endcase
  end

  always_comb begin
    case (stage_q.sel)
      SEL_ALU: result = stage_q.alu;
      SEL_MEM: result = load_val;
      SEL_PC4: result = stage_q.pc_plus4;
      default: result = stage_q.imm;
    endcase
  end

  assign wb_en     = stage_q.valid & stage_q.reg_write & (stage_q.rd != '0);
  assign wb_addr   = stage_q.rd;
  assign wb_data   = result;
  assign fwd_valid = wb_en;
  assign fwd_addr  = wb_addr;
  assign fwd_data  = wb_data;

`ifdef WB_RETIRE_COUNT_EN
  // Counts every completed slot, including non-writing instructions; wraps silently.
  logic [31:0] retire_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_q <= '0;
    end else if (stage_q.valid) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign retire_count = retire_q;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_cpu_step_5_wb.sv
// Directed self-checking bench for cpu_step_5_wb (default WIDTH=32, REG_COUNT=32).
module tb_cpu_step_5_wb;

  localparam int WIDTH = 32;
  localparam int AW    = 5;

`ifdef WB_RETIRE_COUNT_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_flush, in_reg_write, in_load_unsigned;
  logic [1:0]       in_sel, in_load_size, in_byte_offset;
  logic [WIDTH-1:0] in_alu, in_mem, in_pc_plus4, in_imm;
  logic [AW-1:0]    in_rd;
  logic             wb_en, fwd_valid;
  logic [AW-1:0]    wb_addr, fwd_addr;
  logic [WIDTH-1:0] wb_data, fwd_data;
  logic [31:0]      retire_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t lv [9] = '{
    '{2'd0, 1'b0, 2'd0, 32'hFFFF_FF81},
    '{2'd0, 1'b1, 2'd1, 32'h0000_007F},
    '{2'd1, 1'b0, 2'd2, 32'hFFFF_80F0},
    '{2'd1, 1'b0, 2'd3, 32'hFFFF_80F0},
    '{2'd1, 1'b1, 2'd0, 32'h0000_7F81},
    '{2'd0, 1'b0, 2'd3, 32'hFFFF_FF80},
    '{2'd0, 1'b1, 2'd2, 32'h0000_00F0},
    '{2'd2, 1'b0, 2'd1, 32'h80F0_7F81},
    '{2'd3, 1'b1, 2'd0, 32'h80F0_7F81}
  };

  cpu_step_5_wb #(.WIDTH(WIDTH), .REG_COUNT(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_flush(in_flush), .in_sel(in_sel),
    .in_alu(in_alu), .in_mem(in_mem), .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_load_size(in_load_size),
    .in_load_unsigned(in_load_unsigned), .in_byte_offset(in_byte_offset),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 0; in_flush = 0; in_reg_write = 0; in_load_unsigned = 0;
    in_sel = 0; in_load_size = 0; in_byte_offset = 0;
    in_alu = 0; in_mem = 0; in_pc_plus4 = 0; in_imm = 0; in_rd = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    idle();
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    idle();
    tick();
    tick();
    checks++;
    if ({wb_en, wb_addr, wb_data, fwd_valid, fwd_addr, fwd_data, retire_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: got en=%b addr=%0d data=%h fwd=%b/%0d/%h rc=%h, want all zero",
               wb_en, wb_addr, wb_data, fwd_valid, fwd_addr, fwd_data, retire_count);
    end
    rst = 0;
    in_valid = 1; in_reg_write = 1; in_rd = 5; in_alu = 32'hDEAD_BEEF;
    tick();
    checks++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL reset_pre_write: got en=%b addr=%0d data=%h, want 1/5/deadbeef", wb_en, wb_addr, wb_data);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({wb_en, wb_addr, wb_data, fwd_valid, fwd_addr, fwd_data, retire_count} !== '0) begin
      errors++;
      $display("FAIL reset_async: got en=%b addr=%0d data=%h fwd=%b rc=%h, want all zero",
               wb_en, wb_addr, wb_data, fwd_valid, retire_count);
    end
    idle();
    #2 rst = 0;
    tick();
    tick();
    checks++;
    if ({wb_en, retire_count} !== 33'd0) begin
      errors++;
      $display("FAIL reset_release: got en=%b rc=%h, want 0/0", wb_en, retire_count);
    end
  endtask

  task automatic test_alu;
    idle();
    in_valid = 1; in_reg_write = 1; in_rd = 3; in_sel = 0;
    in_alu = 32'h1234_5678; in_imm = 32'h1111_1111; in_mem = 32'h2222_2222;
    tick();
    checks++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd3, 32'h1234_5678}) begin
      errors++;
      $display("FAIL alu_wb: got en=%b addr=%0d data=%h, want 1/3/12345678", wb_en, wb_addr, wb_data);
    end
    checks++;
    if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 5'd3, 32'h1234_5678}) begin
      errors++;
      $display("FAIL alu_fwd: got v=%b addr=%0d data=%h, want 1/3/12345678", fwd_valid, fwd_addr, fwd_data);
    end
    idle();
  endtask

  task automatic test_loads;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_reg_write = 1; in_rd = 9; in_sel = 1;
      in_mem = 32'h80F0_7F81; in_alu = 32'h5555_5555;
      in_load_size = lv[i].size; in_load_unsigned = lv[i].uns; in_byte_offset = lv[i].off;
      tick();
      checks++;
      if ({wb_en, wb_data, fwd_data} !== {1'b1, lv[i].exp, lv[i].exp}) begin
        errors++;
        $display("FAIL load_%0d: got en=%b data=%h fwd=%h, want 1/%h", i, wb_en, wb_data, fwd_data, lv[i].exp);
      end
    end
    idle();
  endtask

  task automatic test_x0_flush;
    do_reset();
    in_valid = 1; in_reg_write = 1; in_rd = 0; in_alu = 32'h0000_FFFF;
    tick();
    checks++;
    if ({wb_en, fwd_valid, wb_addr, wb_data} !== {2'b00, 5'd0, 32'h0000_FFFF}) begin
      errors++;
      $display("FAIL x0_suppress: got en=%b fv=%b addr=%0d data=%h, want 0/0/0/0000ffff",
               wb_en, fwd_valid, wb_addr, wb_data);
    end
    in_rd = 7; in_alu = 32'h0000_0777;
    tick();
    in_flush = 1; in_alu = 32'h0000_0999;
    #1;
    checks++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd7, 32'h0000_0777}) begin
      errors++;
      $display("FAIL flush_no_effect_on_stage: got en=%b addr=%0d data=%h, want 1/7/777", wb_en, wb_addr, wb_data);
    end
    tick();
    checks++;
    if ({wb_en, fwd_valid} !== 2'b00) begin
      errors++;
      $display("FAIL flush_bubble: got en=%b fv=%b, want 0/0", wb_en, fwd_valid);
    end
    checks++;
    if (retire_count !== (RC_EN ? 32'd2 : 32'd0)) begin
      errors++;
      $display("FAIL flush_rc_before: got %0d, want %0d", retire_count, RC_EN ? 2 : 0);
    end
    idle();
    tick();
    checks++;
    if (retire_count !== (RC_EN ? 32'd2 : 32'd0)) begin
      errors++;
      $display("FAIL flush_rc_after: got %0d, want %0d", retire_count, RC_EN ? 2 : 0);
    end
  endtask

  task automatic test_sources;
    idle();
    in_valid = 1; in_reg_write = 1; in_alu = 32'h7777_7777; in_mem = 32'h6666_6666;
    in_sel = 2; in_rd = 10; in_pc_plus4 = 32'h0000_0104; in_imm = 32'h0BAD_0BAD;
    tick();
    checks++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd10, 32'h0000_0104}) begin
      errors++;
      $display("FAIL src_pc4: got en=%b addr=%0d data=%h, want 1/10/00000104", wb_en, wb_addr, wb_data);
    end
    in_sel = 3; in_rd = 11; in_imm = 32'hABCD_0000;
    tick();
    checks++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd11, 32'hABCD_0000}) begin
      errors++;
      $display("FAIL src_imm: got en=%b addr=%0d data=%h, want 1/11/abcd0000", wb_en, wb_addr, wb_data);
    end
    idle();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_reg_write = 1; in_sel = 0;
      in_rd = AW'(20 + i); in_alu = 32'hC0DE_0000 + i;
      tick();
      checks++;
      if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'(20 + i), 32'hC0DE_0000 + i}) begin
        errors++;
        $display("FAIL b2b_%0d: got en=%b addr=%0d data=%h, want 1/%0d/%h",
                 i, wb_en, wb_addr, wb_data, 20 + i, 32'hC0DE_0000 + i);
      end
    end
    idle();
    tick();
    checks++;
    if (wb_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got en=%b, want 0", wb_en);
    end
  endtask

  task automatic test_retire;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      in_valid = 1; in_sel = 0; in_rd = 4; in_alu = i;
      in_flush = (i == 4 || i == 9);
      in_reg_write = !(i == 1 || i == 5 || i == 7);
      tick();
    end
    idle();
    tick();
    checks++;
    if (retire_count !== (RC_EN ? 32'd10 : 32'd0)) begin
      errors++;
      $display("FAIL retire_ten: got %0d, want %0d", retire_count, RC_EN ? 10 : 0);
    end
`ifdef WB_RETIRE_COUNT_EN
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    in_valid = 1; in_reg_write = 0;
    tick();
    idle();
    tick();
    checks++;
    if (retire_count !== 32'd0) begin
      errors++;
      $display("FAIL retire_wrap: got %h, want 00000000", retire_count);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_x0_flush();
    test_sources();
    test_back_to_back();
    test_retire();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
